player_hit_receiver: RTL and testbench

//  Target-side end of the projectile interface: consumes an attacker's ball stream (active/x/y/face)
//  and decides, per frame, whether the ball strikes this player. On a hit: pulses ball_consume back
//  to the attacker's projectile block, applies damage, stun, knockback and i-frames, tracks HP and KO.
//  One instance per player, clocked by the frame tick; outputs feed player movement, HUD and game FSM.

---
 rtl/player_hit_receiver_pkg.sv | 25 ++
 rtl/player_hit_receiver_if.sv | 17 +
 rtl/player_hit_receiver_aabb.sv | 32 +++
 rtl/player_hit_receiver.sv | 148 ++++++++++++++
 tb/tb_player_hit_receiver.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/player_hit_receiver_pkg.sv
// Shared constants for the player hit receiver: coordinate/HP widths,
// screen size, facing encoding and the receiver FSM state codes.
package player_hit_receiver_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned SUM_W    = 11;
  localparam int unsigned HP_W     = 8;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  localparam logic FACE_RIGHT = 1'b0;
  localparam logic FACE_LEFT  = 1'b1;

  localparam logic [1:0] ST_ALIVE  = 2'd0;
  localparam logic [1:0] ST_STUN   = 2'd1;
  localparam logic [1:0] ST_INVULN = 2'd2;
  localparam logic [1:0] ST_KO     = 2'd3;

  // HP subtraction that floors at zero instead of wrapping.
  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                              input logic [HP_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/player_hit_receiver_if.sv
// Projectile stream between an attacker's ball block (master) and the
// target's hit receiver (slave).
//   ball_active/ball_x/ball_y/ball_face : master -> slave
//   ball_consume                        : slave -> master, one-frame despawn pulse
interface player_hit_receiver_if;
  import player_hit_receiver_pkg::*;

  logic               ball_active;
  logic [COORD_W-1:0] ball_x;
  logic [COORD_W-1:0] ball_y;
  logic               ball_face;
  logic               ball_consume;

  modport master (output ball_active, ball_x, ball_y, ball_face, input ball_consume);
  modport slave  (input ball_active, ball_x, ball_y, ball_face, output ball_consume);

endinterface

// File: rtl/player_hit_receiver_aabb.sv
// Combinational axis-aligned box overlap between the ball (S x S) and the
// player hitbox (W x H). Sums are widened to 11 bits so nothing wraps.
//   active            : ball present; no overlap reported otherwise
//   bx/by, tx/ty      : top-left corners of ball and hitbox
//   overlap_c         : boxes intersect
module aabb_overlap
  import player_hit_receiver_pkg::*;
#(
  parameter int unsigned W = 30,
  parameter int unsigned H = 50,
  parameter int unsigned S = 16
) (
  input  logic               active,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic [COORD_W-1:0] tx,
  input  logic [COORD_W-1:0] ty,
  output logic               overlap_c
);

  logic [SUM_W-1:0] bx_w, by_w, tx_w, ty_w;

  assign bx_w = {1'b0, bx};
  assign by_w = {1'b0, by};
  assign tx_w = {1'b0, tx};
  assign ty_w = {1'b0, ty};

  assign overlap_c = active
                   && (bx_w < tx_w + SUM_W'(W)) && (tx_w < bx_w + SUM_W'(S))
                   && (by_w < ty_w + SUM_W'(H)) && (ty_w < by_w + SUM_W'(S));

endmodule

// File: rtl/player_hit_receiver.sv
// Target-side projectile receiver: decides per frame whether the attacker's
// ball strikes this player, then applies damage, stun/knockback, i-frames, KO.
// Optional macro SHIELD_BLOCK_EN: a facing block halves damage and skips stun.
//   frame_clk, Reset (sync, active-high)
//   ball        : projectile stream (slave side, drives ball_consume)
//   target_x/y  : hitbox top-left;  target_face, block_in : shield inputs
//   hit, hp, stunned, knock_dx, ko : registered status outputs
module player_hit_receiver
  import player_hit_receiver_pkg::*;
#(
  parameter int unsigned HITBOX_W      = 30,
  parameter int unsigned HITBOX_H      = 50,
  parameter int unsigned BALL_SIZE     = 16,
  parameter int unsigned DAMAGE        = 10,
  parameter int unsigned MAX_HP        = 100,
  parameter int unsigned STUN_FRAMES   = 12,
  parameter int unsigned INVULN_FRAMES = 30,
  parameter int unsigned KNOCK_SPEED   = 2
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  player_hit_receiver_if.slave  ball,
  input  logic [COORD_W-1:0]    target_x,
  input  logic [COORD_W-1:0]    target_y,
  input  logic                  target_face,
  input  logic                  block_in,
  output logic                  hit,
  output logic [HP_W-1:0]       hp,
  output logic                  stunned,
  output logic [COORD_W-1:0]    knock_dx,
  output logic                  ko
);

  localparam int unsigned MAX_FRAMES = (STUN_FRAMES > INVULN_FRAMES) ? STUN_FRAMES : INVULN_FRAMES;
  localparam int unsigned TIMER_W    = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

  logic [1:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [HP_W-1:0]    hp_q, hp_d;
  logic               face_q, face_d;
  logic               hit_q, hit_d;
  logic               consume_q, consume_d;
  logic               stunned_q, stunned_d;
  logic               ko_q, ko_d;
  logic [COORD_W-1:0] knock_q, knock_d;
  logic               overlap_c;
  logic               blocked_c;

  aabb_overlap #(.W(HITBOX_W), .H(HITBOX_H), .S(BALL_SIZE)) u_aabb (
    .active    (ball.ball_active),
    .bx        (ball.ball_x),
    .by        (ball.ball_y),
    .tx        (target_x),
    .ty        (target_y),
    .overlap_c (overlap_c)
  );

`ifdef SHIELD_BLOCK_EN
  // Blocking only works when facing into the incoming ball.
  assign blocked_c = block_in && (target_face != ball.ball_face);
`else
  logic unused_shield;
  assign unused_shield = ^{block_in, target_face};
  assign blocked_c     = 1'b0;
`endif

  // State register
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q   <= ST_ALIVE;
      timer_q   <= '0;
      hp_q      <= HP_W'(MAX_HP);
      face_q    <= FACE_RIGHT;
      hit_q     <= 1'b0;
      consume_q <= 1'b0;
      stunned_q <= 1'b0;
      ko_q      <= 1'b0;
      knock_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      hp_q      <= hp_d;
      face_q    <= face_d;
      hit_q     <= hit_d;
      consume_q <= consume_d;
      stunned_q <= stunned_d;
      ko_q      <= ko_d;
      knock_q   <= knock_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    hp_d      = hp_q;
    face_d    = face_q;
    hit_d     = 1'b0;
    consume_d = 1'b0;

    case (state_q)
      ST_ALIVE: begin
        if (overlap_c) begin
          hit_d     = 1'b1;
          consume_d = 1'b1;
          face_d    = ball.ball_face;
          if (blocked_c) begin
            hp_d    = sat_sub(hp_q, HP_W'(DAMAGE >> 1));
            state_d = (hp_d == '0) ? ST_KO : ST_INVULN;
            timer_d = TIMER_W'(INVULN_FRAMES - 1);
          end else begin
            hp_d    = sat_sub(hp_q, HP_W'(DAMAGE));
            state_d = (hp_d == '0) ? ST_KO : ST_STUN;
            timer_d = TIMER_W'(STUN_FRAMES - 1);
          end
        end
      end
      ST_STUN: begin
        if (timer_q == '0) begin
          state_d = ST_INVULN;
          timer_d = TIMER_W'(INVULN_FRAMES - 1);
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_INVULN: begin
        if (timer_q == '0) state_d = ST_ALIVE;
        else               timer_d = timer_q - TIMER_W'(1);
      end
      default: ;
    endcase

    // Status flags follow the state being entered so they line up with it.
    stunned_d = (state_d == ST_STUN);
    ko_d      = (state_d == ST_KO);
    if (!stunned_d)                knock_d = '0;
    else if (face_d == FACE_LEFT)  knock_d = COORD_W'(0) - COORD_W'(KNOCK_SPEED);
    else                           knock_d = COORD_W'(KNOCK_SPEED);
  end

  assign ball.ball_consume = consume_q;
  assign hit               = hit_q;
  assign hp                = hp_q;
  assign stunned           = stunned_q;
  assign knock_dx          = knock_q;
  assign ko                = ko_q;

endmodule

// File: tb/tb_player_hit_receiver.sv
// Randomized + directed bench for player_hit_receiver with a frame-level
// reference model (HP, remaining stun/i-frame counts, KO flag).
module tb_player_hit_receiver;

  localparam int W = 30, H = 50, S = 16, DMG = 10, MAXHP = 100;
  localparam int STUN = 12, INV = 30, KNOCK = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] target_x, target_y;
  logic       target_face, block_in;
  logic       hit, stunned, ko;
  logic [7:0] hp;
  logic [9:0] knock_dx;

  player_hit_receiver_if bif ();

  player_hit_receiver dut (
    .frame_clk  (clk),
    .Reset      (rst),
    .ball       (bif),
    .target_x   (target_x),
    .target_y   (target_y),
    .target_face(target_face),
    .block_in   (block_in),
    .hit        (hit),
    .hp         (hp),
    .stunned    (stunned),
    .knock_dx   (knock_dx),
    .ko         (ko)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int m_hp = MAXHP, m_stun = 0, m_inv = 0;
  bit m_ko = 0, m_hit = 0, m_face = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_overlap();
    int bx, by, tx, ty;
    bx = int'(bif.ball_x); by = int'(bif.ball_y);
    tx = int'(target_x);   ty = int'(target_y);
    return bif.ball_active && (bx < tx + W) && (tx < bx + S) && (by < ty + H) && (ty < by + S);
  endfunction

  task automatic model_edge();
    bit blk;
    int dmg;
    m_hit = 0;
    if (rst) begin
      m_hp = MAXHP; m_stun = 0; m_inv = 0; m_ko = 0;
    end else if (m_ko) begin
    end else if (m_stun > 0) begin
      m_stun--;
      if (m_stun == 0) m_inv = INV;
    end else if (m_inv > 0) begin
      m_inv--;
    end else if (model_overlap()) begin
`ifdef SHIELD_BLOCK_EN
      blk = block_in && (target_face != bif.ball_face);
`else
      blk = 0;
`endif
      dmg    = blk ? DMG / 2 : DMG;
      m_hp   = (m_hp > dmg) ? m_hp - dmg : 0;
      m_hit  = 1;
      m_face = bif.ball_face;
      if (m_hp == 0) m_ko = 1;
      else if (blk)  m_inv = INV;
      else           m_stun = STUN;
    end
  endtask

  task automatic step();
    logic [9:0] exp_knock;
    @(posedge clk);
    model_edge();
    #1;
    exp_knock = (m_stun > 0) ? (m_face ? 10'(-KNOCK) : 10'(KNOCK)) : 10'd0;
    check("hit",     32'(hit),              32'(m_hit));
    check("consume", 32'(bif.ball_consume), 32'(m_hit));
    check("hp",      32'(hp),               32'(m_hp));
    check("stunned", 32'(stunned),          32'(m_stun > 0));
    check("ko",      32'(ko),               32'(m_ko));
    check("knock",   32'(knock_dx),         32'(exp_knock));
  endtask

  task automatic set_ball(input bit act, input int x, input int y, input bit face);
    bif.ball_active = act;
    bif.ball_x      = 10'(x);
    bif.ball_y      = 10'(y);
    bif.ball_face   = face;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1; target_x = 10'd100; target_y = 10'd200; target_face = 1'b0; block_in = 1'b0;
    set_ball(0, 0, 0, 0);

    // reset values
    step(); step();
    rst = 1'b0;
    check("rst_hp", 32'(hp), 32'd100);
    check("rst_knock", 32'(knock_dx), 32'd0);

    // first hit, stun with +2 knockback, then i-frames
    set_ball(1, 120, 230, 0);
    step();
    check("first_hit", 32'(hit), 32'd1);
    check("first_hp", 32'(hp), 32'd90);
    for (int i = 0; i < 11; i++) step();
    check("stun_knock", 32'(knock_dx), 32'd2);
    step();
    check("stun_end", 32'(stunned), 32'd0);
    for (int i = 0; i < 30; i++) step();
    check("invuln_hp", 32'(hp), 32'd90);
    step();
    check("second_hit_hp", 32'(hp), 32'd80);

    // hit repeatedly until KO
    k = 0;
    while (!ko && k < 1000) begin step(); k++; end
    check("ko_reached", 32'(ko), 32'd1);
    check("ko_hp", 32'(hp), 32'd0);
    for (int i = 0; i < 5; i++) step();
    do_reset();
    check("post_ko_rst_hp", 32'(hp), 32'd100);

    // inactive ball and far-away ball never hit
    set_ball(0, 120, 230, 0);
    step(); step();
    check("inactive_hit", 32'(hit), 32'd0);
    set_ball(1, 600, 200, 0);
    step(); step();
    check("far_hit", 32'(hit), 32'd0);

    // ball moving left knocks to the left
    set_ball(1, 110, 210, 1);
    step();
    step();
    check("left_knock", 32'(knock_dx), 32'h3FE);
    do_reset();

`ifdef SHIELD_BLOCK_EN
    target_face = 1'b1; block_in = 1'b1;
    set_ball(1, 120, 230, 0);
    step();
    check("block_hp", 32'(hp), 32'd95);
    check("block_consume", 32'(bif.ball_consume), 32'd1);
    check("block_stun", 32'(stunned), 32'd0);
    check("block_knock", 32'(knock_dx), 32'd0);
    do_reset();
`endif

    // randomized frames
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) begin
        target_x = 10'($urandom);
        target_y = 10'($urandom);
      end
      target_face = 1'($urandom);
      block_in    = 1'($urandom);
      if ($urandom_range(0, 7) == 0)
        set_ball(1'($urandom), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'($urandom));
      else
        set_ball($urandom_range(0, 4) != 0,
                 int'(target_x) + int'($urandom_range(0, 80)) - 40,
                 int'(target_y) + int'($urandom_range(0, 100)) - 50,
                 1'($urandom));
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
